// File: rtl/bram_pkg.sv
// Shared definitions for the streaming block-RAM port: FSM encodings and
// elaboration-time helper functions.
package bram_pkg;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Returns at least 1 so single-entry structures still get a legal vector.
  function automatic int clog2(input int value);
    int result = 1;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  function automatic bit latency_legal(input int latency);
    return (latency == 1) || (latency == 2);
  endfunction

endpackage

// File: rtl/bram_rsp_buffer.sv
// First-word-fall-through FIFO holding read responses the consumer has not
// yet taken; head_data is valid whenever count is non-zero.
module bram_rsp_buffer
  import bram_pkg::*;
#(
  parameter int width = 32,
  parameter int depth = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [width-1:0]            push_data,
  input  logic                        pop,
  output logic [width-1:0]            head_data,
  output logic [clog2(depth+1)-1:0]   count
);

  localparam int PTR_W = clog2(depth);
  localparam int CNT_W = clog2(depth + 1);

  logic [width-1:0] slots [depth];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: the storage array has no reset; only pointers and count do, so the
  // slots can map onto plain registers or distributed RAM.
  always_ff @(posedge clk) begin
    if (push) slots[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(depth - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(depth - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head_data = slots[rd_ptr];

endmodule

// File: rtl/bram_stream_port.sv
// Valid/ready request/response wrapper around an inferred block RAM with an
// optional zero-sweep after reset and a skid buffer sized to never drop data.
module bram_stream_port
  import bram_pkg::*;
#(
  parameter int    mem_width        = 32,
  parameter int    mem_depth        = 4096,
  parameter int    read_latency     = 2,
  parameter string byte_write_mode  = "false",
  parameter string init_on_reset    = "true",
  parameter int    simulation_delay = 1
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   req_valid,
  output logic                                                   req_ready,
  input  logic                                                   req_write,
  input  logic [clog2(mem_depth)-1:0]                            req_addr,
  input  logic [mem_width-1:0]                                   req_wdata,
  input  logic [((byte_write_mode == "true") ? mem_width/8 : 1)-1:0] req_wstrb,
  output logic                                                   rsp_valid,
  input  logic                                                   rsp_ready,
  output logic [mem_width-1:0]                                   rsp_rdata,
  output logic                                                   init_done
);

  localparam int         ADDR_W    = clog2(mem_depth);
  localparam bit         BYTE_MODE = (byte_write_mode == "true");
  localparam bit         SWEEP_EN  = (init_on_reset == "true");
  localparam int         STRB_W    = BYTE_MODE ? mem_width / 8 : 1;
  localparam int         LANE_W    = BYTE_MODE ? 8 : mem_width;
  localparam int         BUF_DEPTH = read_latency + 1;
  localparam int         CNT_W     = clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BUF_DEPTH);
  localparam logic [0:0]       ST_RESET = SWEEP_EN ? ST_INIT : ST_RUN;

  if (!latency_legal(read_latency)) begin : g_bad_latency
    $error("bram_stream_port: read_latency must be 1 or 2");
  end
  if (BYTE_MODE && (mem_width % 8 != 0)) begin : g_bad_width
    $error("bram_stream_port: mem_width must be a multiple of 8 in byte mode");
  end
  if (simulation_delay < 0) begin : g_bad_delay
    $error("bram_stream_port: simulation_delay must not be negative");
  end

  // ---------------------------------------------------------------- FSM
  logic [0:0]        state;
  logic [ADDR_W-1:0] sweep_addr;
  logic              sweep_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RESET;
      sweep_addr <= '0;
    end else if (state == ST_INIT) begin
      sweep_addr <= sweep_addr + 1'b1;
      if (sweep_addr == ADDR_W'(mem_depth - 1)) state <= ST_RUN;
    end
  end

  assign sweep_we  = (state == ST_INIT);
  assign init_done = (state == ST_RUN);

  // ---------------------------------------------------------- handshake
  logic [CNT_W-1:0] outstanding;
  logic             req_fire;
  logic             rd_fire;
  logic             wr_fire;
  logic             rsp_fire;

  // Every accepted read owns a slot in pipeline-or-buffer until handshaken,
  // so capping outstanding at the buffer depth guarantees no overflow.
  assign req_ready = rst_n && init_done && (outstanding < CNT_MAX);
  assign req_fire  = req_valid && req_ready;
  assign rd_fire   = req_fire && !req_write;
  assign wr_fire   = req_fire && req_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else if (rd_fire && !rsp_fire) begin
      outstanding <= outstanding + 1'b1;
    end else if (!rd_fire && rsp_fire) begin
      outstanding <= outstanding - 1'b1;
    end
  end

  // ------------------------------------------------------ memory + pipe
  logic [mem_width-1:0]    mem       [mem_depth];
  logic [mem_width-1:0]    pipe_data [read_latency];
  logic [read_latency-1:0] pipe_valid;
  logic                    pipe_out_valid;
  logic [mem_width-1:0]    pipe_out_data;

  // NOTE: the array and the read-data stages carry no reset so synthesis can
  // map them onto block RAM and its output registers; the sweep clears data.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sweep_addr] <= '0;
    end else if (wr_fire) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (req_wstrb[b]) mem[req_addr][b*LANE_W +: LANE_W] <= req_wdata[b*LANE_W +: LANE_W];
      end
    end
    if (rd_fire) pipe_data[0] <= mem[req_addr];
    for (int k = 1; k < read_latency; k++) pipe_data[k] <= pipe_data[k-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= rd_fire;
      for (int k = 1; k < read_latency; k++) pipe_valid[k] <= pipe_valid[k-1];
    end
  end

  assign pipe_out_valid = pipe_valid[read_latency-1];
  assign pipe_out_data  = pipe_data[read_latency-1];

  // ---------------------------------------------------- response buffer
  logic [mem_width-1:0] buf_head;
  logic [CNT_W-1:0]     buf_count;
  logic                 buf_empty;
  logic                 buf_push;
  logic                 buf_pop;

  assign buf_empty = (buf_count == '0);
  // Bypass the buffer only when it is empty and the consumer takes the word;
  // otherwise the RAM output queues behind older responses to keep order.
  assign buf_push  = pipe_out_valid && (!buf_empty || !rsp_ready);
  assign buf_pop   = !buf_empty && rsp_ready;

  bram_rsp_buffer #(
    .width (mem_width),
    .depth (BUF_DEPTH)
  ) u_rsp_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (buf_push),
    .push_data (pipe_out_data),
    .pop       (buf_pop),
    .head_data (buf_head),
    .count     (buf_count)
  );

  assign rsp_valid = !buf_empty || pipe_out_valid;
  assign rsp_rdata = !buf_empty     ? buf_head      :
                     pipe_out_valid ? pipe_out_data : '0;
  assign rsp_fire  = rsp_valid && rsp_ready;

endmodule

// File: tb/tb_bram_stream_port.sv
// Directed bench for bram_stream_port: scoreboard of expected read data fed
// at request acceptance and drained by a response monitor.
module tb_bram_stream_port;

  localparam int LAT   = 2;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        init_done;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          stalls   = 0;
  logic [31:0] exp_q[$];
  int          rsp_cyc_q[$];
  logic [31:0] model [DEPTH];

  bram_stream_port #(
    .mem_width        (32),
    .mem_depth        (DEPTH),
    .read_latency     (LAT),
    .byte_write_mode  ("true"),
    .init_on_reset    ("true"),
    .simulation_delay (1)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response monitor: a handshake seen at the falling edge completes on the
  // next rising edge, since inputs only change just after rising edges.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      rsp_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) check("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
      else check("rsp_data", rsp_rdata, exp_q.pop_front());
    end
  end

  task automatic do_req(input logic wr, input logic [3:0] addr, input logic [31:0] data,
                        input logic [3:0] strb);
    int waited = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = data;
    req_wstrb = strb;
    @(negedge clk);
    while (req_ready !== 1'b1 && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    stalls += waited;
    if (waited >= 50) begin
      check("req_accept_timeout", {31'd0, req_ready}, 32'd1);
    end else if (wr) begin
      for (int b = 0; b < 4; b++) if (strb[b]) model[addr][b*8 +: 8] = data[b*8 +: 8];
    end else begin
      exp_q.push_back(model[addr]);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wr_word(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    do_req(1'b1, addr, data, strb);
  endtask

  task automatic rd_word(input logic [3:0] addr);
    do_req(1'b0, addr, 32'd0, 4'd0);
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("drain_empty", exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_init(input string tag);
    int cnt = 0;
    int ready_seen = 0;
    @(negedge clk);
    while (init_done !== 1'b1 && cnt < 100) begin
      cnt++;
      if (req_ready === 1'b1) ready_seen++;
      @(negedge clk);
    end
    check({tag, "_cycles"}, cnt, DEPTH);
    check({tag, "_ready_low"}, ready_seen, 32'd0);
    check({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int span;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);

    // Zero sweep, then every address reads back zero
    rst_n = 1'b1;
    wait_init("init");
    for (int i = 0; i < DEPTH; i++) rd_word(4'(i));
    drain();

    // Read immediately after write to the same address, with latency check
    wr_word(4'd5, 32'hDEADBEEF, 4'hF);
    rd_word(4'd5);
    @(negedge clk);
    check("lat_early", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check("lat_valid", {31'd0, rsp_valid}, 32'd1);
    check("lat_data", rsp_rdata, 32'hDEADBEEF);
    drain();

    // Byte-strobe merge
    wr_word(4'd3, 32'h11223344, 4'hF);
    wr_word(4'd3, 32'hAABBCCDD, 4'b0101);
    rd_word(4'd3);
    @(negedge clk);
    @(negedge clk);
    check("byte_merge", rsp_rdata, 32'h11BB33DD);
    drain();

    // Back-pressure: buffer fills after LAT+1 reads, then drains in order
    for (int i = 0; i < 8; i++) wr_word(4'(i), 32'hA5000000 | 32'(i * 32'h00010203), 4'hF);
    rsp_ready = 1'b0;
    stalls    = 0;
    for (int i = 0; i < LAT + 1; i++) rd_word(4'(i));
    check("accepts_before_full", stalls, 32'd0);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 4'd3;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("full_ready_low", {31'd0, req_ready}, 32'd0);
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_data", rsp_rdata, exp_q[0]);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    for (int i = LAT + 1; i < 8; i++) rd_word(4'(i));
    drain();

    // Full-rate streaming
    rsp_cyc_q.delete();
    stalls = 0;
    for (int i = 0; i < 20; i++) rd_word(4'(i % DEPTH));
    drain();
    check("burst_stalls", stalls, 32'd0);
    check("burst_rsp_count", rsp_cyc_q.size(), 32'd20);
    span = (rsp_cyc_q.size() >= 20) ? rsp_cyc_q[19] - rsp_cyc_q[0] : -1;
    check("burst_span", span, 32'd19);

    // Reset with two reads in flight
    rd_word(4'd1);
    rd_word(4'd2);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midrst_req_ready", {31'd0, req_ready}, 32'd0);
    check("midrst_outstanding", 32'(u_dut.outstanding), 32'd0);
    check("midrst_rsp_rdata", rsp_rdata, 32'd0);
    exp_q.delete();
    rsp_cyc_q.delete();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_init("reinit");
    repeat (5) @(negedge clk);
    check("no_stale_rsp", rsp_cyc_q.size(), 32'd0);
    @(posedge clk); #1;
    rd_word(4'd5);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_stream_port.md
BRAM_STREAM_PORT -- requirements
Module: bram_stream_port

Interface
REQ-001 SHALL have parameter mem_width, default 32, data width in bits; must be a multiple of 8 when byte_write_mode="true".
REQ-002 SHALL have parameter mem_depth, default 4096, number of words.
REQ-003 SHALL have parameter read_latency, default 2, RAM read pipeline depth; legal values are 1 or 2.
REQ-004 SHALL have parameter byte_write_mode, default "false", which enables per-byte write strobes when "true".
REQ-005 SHALL have parameter init_on_reset, default "true", which enables a hardware zero-sweep after reset when "true".
REQ-006 SHALL have parameter simulation_delay, default 1, a simulation-only register delay.
REQ-007 SHALL have port clk, input, 1 bit: the single clock.
REQ-008 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have port req_valid / req_ready, input / output, 1 bit each: request handshake.
REQ-010 SHALL have port req_write, input, 1 bit: 1 = write, 0 = read.
REQ-011 SHALL have port req_addr, input, clog2(mem_depth) bits: word address.
REQ-012 SHALL have port req_wdata, input, mem_width bits: write data.
REQ-013 SHALL have port req_wstrb, input, mem_width/8 bits (1 bit when byte_write_mode="false"): write enables.
REQ-014 SHALL have port rsp_valid / rsp_ready, output / input, 1 bit each: read-response handshake.
REQ-015 SHALL have port rsp_rdata, output, mem_width bits: read data.
REQ-016 SHALL have port init_done, output, 1 bit: high once the memory is usable.

Function
REQ-017 SHALL accept a request on any clk edge where req_valid and req_ready are both high; at most one request per cycle; a write and a read are never accepted in the same cycle.
REQ-018 SHALL update the memory on the accept edge of a write; bytes whose req_wstrb bit is 0 are left unchanged; no response is generated for a write.
REQ-019 SHALL return read responses strictly in acceptance order.
REQ-020 SHALL assert rsp_valid exactly read_latency cycles after a read is accepted, provided the response buffer is empty, via bypass of the RAM output.
REQ-021 SHALL, when rsp_ready is low, capture arriving read data into a first-word-fall-through response buffer of depth read_latency+1; data is never dropped.
REQ-022 SHALL maintain an outstanding counter: +1 on each read accept, -1 on each response handshake, net 0 when both occur in one cycle; the counter never exceeds read_latency+1.
REQ-023 SHALL drive req_ready = init_done AND (outstanding < read_latency+1); req_ready does not depend on req_valid or req_write.
REQ-024 SHALL sustain 1 read per cycle when rsp_ready is held high.
REQ-025 SHALL return post-write data for a read accepted the cycle after a write to the same address.
REQ-026 SHALL hold rsp_valid and rsp_rdata stable while rsp_valid is high and rsp_ready is low.
REQ-027 SHALL implement a two-state FSM: INIT and RUN.
- INIT: writes zero to addresses 0..mem_depth-1, one per cycle; req_ready=0; moves to RUN after the last address (mem_depth cycles).
- RUN: normal operation; init_done=1.
- When init_on_reset="false", the FSM enters RUN directly.

Reset
REQ-028 SHALL, when rst_n is low (asynchronous), clear the FSM state (to INIT or RUN per parameter), the sweep address, the outstanding counter, the buffer pointers and all read-pipeline valid bits.
REQ-029 SHALL drive the following reset values: req_ready=0, rsp_valid=0, init_done=0 (1 when init_on_reset="false"), rsp_rdata=0.
REQ-030 SHALL, on reset during operation, discard all in-flight reads; memory contents are not reset except by the INIT sweep.

Structure
REQ-031 SHALL keep FSM encodings and the clog2 function in a shared package (bram_pkg); read_latency legality is checked there via an elaboration-time assertion.
REQ-032 SHALL contain a single sub-module, bram_rsp_buffer: a parametrised FWFT FIFO with a count output, used for the response buffer.
REQ-033 SHALL infer the memory array inline as block RAM, with a read-latency shift register of data and valid bits.

Verification
REQ-034 SHALL cover: init_on_reset="true", mem_depth=16 -> req_ready=0 for 16 cycles after reset release, then init_done=1; reads of addresses 0..15 all return 0.
REQ-035 SHALL cover: write 0xDEADBEEF to address 5, then read address 5 on the next cycle -> rsp_valid exactly read_latency cycles later with 0xDEADBEEF.
REQ-036 SHALL cover: byte_write_mode="true"; address 3 holds 0x11223344; write 0xAABBCCDD with req_wstrb=4'b0101 -> a read returns 0x11BB33DD.
REQ-037 SHALL cover: 8 back-to-back reads with rsp_ready=0 -> req_ready drops after read_latency+1 accepts; on raising rsp_ready, the remaining reads complete in order with no loss.
REQ-038 SHALL cover: 20 back-to-back reads with rsp_ready=1 -> one response per cycle, in order, with req_ready never low.
REQ-039 SHALL cover: assert rst_n low with 2 reads in flight -> rsp_valid=0 immediately, the outstanding count is 0, and no stale response appears after reset release.
